// File: rtl/mac_regif_pkg.sv
// Shared constants for the MAC slave register interface: register map,
// STATUS bit positions and the control FSM state encoding.
package mac_regif_pkg;

    localparam int unsigned OFF_OPA    = 0;
    localparam int unsigned OFF_OPB    = 1;
    localparam int unsigned OFF_INT_EN = 2;
    localparam int unsigned OFF_START  = 3;
    localparam int unsigned OFF_CLEAR  = 4;
    localparam int unsigned OFF_STATUS = 5;
    localparam int unsigned OFF_RESULT = 6;

    // STATUS layout from bit 0: busy, done, ovfA, ovfB, opA_count, opB_count
    localparam int unsigned ST_BUSY_BIT = 0;
    localparam int unsigned ST_DONE_BIT = 1;
    localparam int unsigned ST_OVFA_BIT = 2;
    localparam int unsigned ST_OVFB_BIT = 3;
    localparam int unsigned ST_CNTA_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/mac_regif_fsm.sv
// IDLE/BUSY/DONE control machine for the MAC engine, including the sticky
// done flag (set on engine completion, cleared by start, clear or W1C).
module mac_regif_fsm
    import mac_regif_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start_req,
    input  logic       i_clear_req,
    input  logic       i_op_done,
    input  logic       i_done_w1c,
    output fsm_state_e o_state,
    output logic       o_done,
    output logic       o_start_ok_c
);

    fsm_state_e r_state;
    fsm_state_e w_state_nxt;
    logic       r_done;
    logic       w_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Clear overrides everything; a completion in the same cycle as a W1C wins
    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = r_done;
        o_start_ok_c = 1'b0;
        if (i_done_w1c) begin
            w_done_nxt = 1'b0;
        end
        if (i_clear_req) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start_req) begin
                        w_state_nxt  = ST_BUSY;
                        w_done_nxt   = 1'b0;
                        o_start_ok_c = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (i_op_done) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_done  = r_done;

endmodule

// File: rtl/mac_slave_regif.sv
// Slave register interface for a MAC engine: operand pushes, start/clear
// control, status/result readback and a done interrupt.
module mac_slave_regif
    import mac_regif_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RES_DEPTH  = 8,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned RA_W      = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    output logic [DATA_W-1:0] opA_data,
    output logic [DATA_W-1:0] opB_data,
    output logic              opA_we,
    output logic              opB_we,
    input  logic [CNT_W-1:0]  opA_count,
    input  logic [CNT_W-1:0]  opB_count,
    output logic              op_start,
    output logic              op_mode,
    output logic              op_clear,
    input  logic              op_done,
    input  logic [DATA_W-1:0] result,
    output logic [RA_W-1:0]   rAddr,
    output logic              m_interrupt
);

    localparam int unsigned ST_CNTB_LSB = ST_CNTA_LSB + CNT_W;

    logic              w_wr, w_rd;
    logic              w_wr_opa, w_wr_opb, w_push_a, w_push_b;
    logic              w_wr_status, w_start_req, w_clear_req, w_rd_result;
    logic              w_done, w_busy, w_start_ok_c;
    fsm_state_e        w_state;
    logic [DATA_W-1:0] w_status;

    logic [DATA_W-1:0] r_opa_data, r_opb_data;
    logic              r_opa_we, r_opb_we;
    logic              r_op_start, r_op_mode, r_op_clear;
    logic              r_ovf_a, r_ovf_b, r_int_en, r_irq;
    logic [RA_W-1:0]   r_raddr;

    assign w_wr        = S_sel & S_wr;
    assign w_rd        = S_sel & ~S_wr;
    assign w_wr_opa    = w_wr & (S_address == ADDR_W'(OFF_OPA));
    assign w_wr_opb    = w_wr & (S_address == ADDR_W'(OFF_OPB));
    assign w_push_a    = w_wr_opa & (opA_count < CNT_W'(FIFO_DEPTH));
    assign w_push_b    = w_wr_opb & (opB_count < CNT_W'(FIFO_DEPTH));
    assign w_wr_status = w_wr & (S_address == ADDR_W'(OFF_STATUS));
    assign w_start_req = w_wr & (S_address == ADDR_W'(OFF_START)) & S_din[0];
    assign w_clear_req = w_wr & (S_address == ADDR_W'(OFF_CLEAR)) & S_din[0];
    assign w_rd_result = w_rd & (S_address == ADDR_W'(OFF_RESULT));
    assign w_busy      = (w_state == ST_BUSY);

    mac_regif_fsm u_fsm (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_start_req  (w_start_req),
        .i_clear_req  (w_clear_req),
        .i_op_done    (op_done),
        .i_done_w1c   (w_wr_status & S_din[ST_DONE_BIT]),
        .o_state      (w_state),
        .o_done       (w_done),
        .o_start_ok_c (w_start_ok_c)
    );

    // Operand pushes and control pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opa_data <= '0;
            r_opb_data <= '0;
            r_opa_we   <= 1'b0;
            r_opb_we   <= 1'b0;
            r_op_start <= 1'b0;
            r_op_mode  <= 1'b0;
            r_op_clear <= 1'b0;
        end else begin
            r_opa_we   <= w_push_a;
            r_opb_we   <= w_push_b;
            r_op_start <= w_start_ok_c;
            r_op_clear <= w_clear_req;
            if (w_push_a) r_opa_data <= S_din;
            if (w_push_b) r_opb_data <= S_din;
            if (w_start_ok_c) r_op_mode <= S_din[1];
        end
    end

    // Sticky overflow flags, interrupt enable, result pointer, interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_a  <= 1'b0;
            r_ovf_b  <= 1'b0;
            r_int_en <= 1'b0;
            r_raddr  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= r_int_en & w_done;
            if (w_wr & (S_address == ADDR_W'(OFF_INT_EN))) r_int_en <= S_din[0];
            if (w_clear_req) begin
                r_ovf_a <= 1'b0;
                r_ovf_b <= 1'b0;
                r_raddr <= '0;
            end else begin
                if (w_wr_opa & ~w_push_a) r_ovf_a <= 1'b1;
                else if (w_wr_status & S_din[ST_OVFA_BIT]) r_ovf_a <= 1'b0;
                if (w_wr_opb & ~w_push_b) r_ovf_b <= 1'b1;
                else if (w_wr_status & S_din[ST_OVFB_BIT]) r_ovf_b <= 1'b0;
                if (w_rd_result) begin
                    if (r_raddr == RA_W'(RES_DEPTH - 1)) r_raddr <= '0;
                    else r_raddr <= r_raddr + RA_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_status                       = '0;
        w_status[ST_BUSY_BIT]          = w_busy;
        w_status[ST_DONE_BIT]          = w_done;
        w_status[ST_OVFA_BIT]          = r_ovf_a;
        w_status[ST_OVFB_BIT]          = r_ovf_b;
        w_status[ST_CNTA_LSB +: CNT_W] = opA_count;
        w_status[ST_CNTB_LSB +: CNT_W] = opB_count;
    end

    // Combinational read mux; unmapped and write-only offsets read 0
    always_comb begin
        S_dout = '0;
        if (w_rd) begin
            case (S_address)
                ADDR_W'(OFF_INT_EN): S_dout = DATA_W'(r_int_en);
                ADDR_W'(OFF_STATUS): S_dout = w_status;
                ADDR_W'(OFF_RESULT): S_dout = result;
                default:             S_dout = '0;
            endcase
        end
    end

    assign opA_data    = r_opa_data;
    assign opB_data    = r_opb_data;
    assign opA_we      = r_opa_we;
    assign opB_we      = r_opb_we;
    assign op_start    = r_op_start;
    assign op_mode     = r_op_mode;
    assign op_clear    = r_op_clear;
    assign rAddr       = r_raddr;
    assign m_interrupt = r_irq;

endmodule
